mux_nx1_rr: RTL

MUX_NX1_RR -- requirements
Module: mux_nx1_rr

---
 rtl/mux_nx1_rr.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mux_nx1_rr.sv
// N-to-1 registered multiplexer with a valid/ready handshake on every channel.
// The channel is picked either by the sel input or by a round-robin pointer.
module mux_nx1_rr #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MODE   = 0,
    localparam int unsigned SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]     ptr_q,       ptr_d;

    logic                 load_en_c;
    logic                 accept_c;
    logic                 grant_vld_c;
    logic [SEL_W-1:0]     grant_idx_c;
    logic [DATA_W-1:0]    grant_data_c;
    logic [N_CH-1:0]      in_ready_c;
    int unsigned          dist_c;
    int unsigned          best_dist_c;

    // The output register can take a word when empty or when draining this cycle.
    assign load_en_c = !out_valid_q || out_ready;
    assign accept_c  = !rst && grant_vld_c && load_en_c;

    // Grant selection: direct select, or the valid channel nearest after ptr.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        dist_c      = 0;
        best_dist_c = N_CH;
        if (MODE == 0) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (SEL_W'(i) == sel && in_valid[i]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (in_valid[i]) begin
                    dist_c = (i + N_CH - 32'(ptr_q)) % N_CH;
                    if (dist_c < best_dist_c) begin
                        best_dist_c = dist_c;
                        grant_vld_c = 1'b1;
                        grant_idx_c = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Data path mux; depends only on the grant index, never feeds back into ready.
    always_comb begin
        grant_data_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == grant_idx_c) begin
                grant_data_c = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        in_ready_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            in_ready_c[i] = accept_c && (grant_idx_c == SEL_W'(i));
        end
    end

    // Next-state: load beats drain, so a simultaneous drain+load keeps valid high.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data_c;
            out_ch_d    = grant_idx_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (MODE == 1 && accept_c) begin
            ptr_d = (32'(grant_idx_c) == N_CH - 1) ? '0 : grant_idx_c + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
